frog_controller: RTL

Moves the frog on the playfield grid from the four debounced switches. Tracks lives and detects collision deaths and game over. Sits directly upstream of level_counter: it produces frog_at_top, lives and reset_level, and consumes reset_frog. All state is held here; outputs are registered.

---
 rtl/frog_controller.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/frog_controller.sv
`default_nettype none
// ============================================================================
// Module      : frog_controller
// Description : Moves the frog across the playfield grid from four debounced
//               switches. It tracks the remaining lives, handles collision
//               deaths with a timed freeze and respawn, and detects game over.
//               All outputs are registered.
//
// Ports       : clk            system clock (single domain)
//               rst_n          asynchronous active-low reset
//               debounced_sw1  move up    (y-1)
//               debounced_sw2  move down  (y+1)
//               debounced_sw3  move left  (x-1)
//               debounced_sw4  move right (x+1)
//               collision      obstacle hit on the current frog cell (level)
//               reset_frog     return frog to the start cell (from level_counter)
//               frog_x         frog column, 0..GRID_W-1
//               frog_y         frog row, 0 = goal row, GRID_H-1 = start row
//               frog_at_top    high while frog_y==0 and the frog is alive
//               lives          lives remaining
//               reset_level    one-cycle pulse on entry to game over
//
// Options     : FROG_WRAP_X_EN - when defined, horizontal moves wrap around
//               the grid edges instead of clamping. Vertical moves always clamp.
//
// Revision    : 1.0 - initial release
// ============================================================================
module frog_controller #(
    parameter int GRID_W      = 20,
    parameter int GRID_H      = 15,
    parameter int START_LIVES = 3,
    parameter int DEATH_HOLD  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       debounced_sw1,
    input  logic       debounced_sw2,
    input  logic       debounced_sw3,
    input  logic       debounced_sw4,
    input  logic       collision,
    input  logic       reset_frog,
    output logic [4:0] frog_x,
    output logic [3:0] frog_y,
    output logic       frog_at_top,
    output logic [1:0] lives,
    output logic       reset_level
);

    // The hold counter counts 0..DEATH_HOLD-1 while dying.
    localparam int               c_CNT_W       = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;
    localparam logic [4:0]       c_START_X     = 5'(GRID_W / 2);
    localparam logic [4:0]       c_MAX_X       = 5'(GRID_W - 1);
    localparam logic [3:0]       c_MAX_Y       = 4'(GRID_H - 1);
    localparam logic [1:0]       c_START_LIVES = 2'(START_LIVES);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT  = c_CNT_W'(DEATH_HOLD - 1);

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DYING     = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t               r_state, w_state_d;
    logic [4:0]           r_x, w_x_d, w_mv_x;
    logic [3:0]           r_y, w_y_d, w_mv_y;
    logic [1:0]           r_lives, w_lives_d;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_d;
    logic [3:0]           r_sw_q;
    logic                 r_top, w_top_d;
    logic                 r_reset_level, w_reset_level_d;

    logic [3:0]           w_sw;
    logic [3:0]           w_edge;
    logic                 w_all_sw;
    logic                 w_any_edge;

    // Bit 0 is up, bit 3 is right: the index order is the move priority.
    assign w_sw       = {debounced_sw4, debounced_sw3, debounced_sw2, debounced_sw1};
    assign w_edge     = w_sw & ~r_sw_q;
    assign w_all_sw   = &w_sw;
    assign w_any_edge = |w_edge;

    // Candidate position for this cycle's single highest-priority move.
    always_comb begin
        w_mv_x = r_x;
        w_mv_y = r_y;
        if (w_edge[0]) begin
            w_mv_y = (r_y == 4'd0) ? 4'd0 : r_y - 4'd1;
        end else if (w_edge[1]) begin
            w_mv_y = (r_y == c_MAX_Y) ? c_MAX_Y : r_y + 4'd1;
        end else if (w_edge[2]) begin
`ifdef FROG_WRAP_X_EN
            w_mv_x = (r_x == 5'd0) ? c_MAX_X : r_x - 5'd1;
`else
            w_mv_x = (r_x == 5'd0) ? 5'd0 : r_x - 5'd1;
`endif
        end else if (w_edge[3]) begin
`ifdef FROG_WRAP_X_EN
            w_mv_x = (r_x == c_MAX_X) ? 5'd0 : r_x + 5'd1;
`else
            w_mv_x = (r_x == c_MAX_X) ? c_MAX_X : r_x + 5'd1;
`endif
        end
    end

    // Next-state logic. Order of the checks encodes the in-cycle priority:
    // all-switch restart, then reset_frog, then collision, then moves.
    always_comb begin
        w_state_d       = r_state;
        w_x_d           = r_x;
        w_y_d           = r_y;
        w_lives_d       = r_lives;
        w_cnt_d         = r_cnt;
        w_reset_level_d = 1'b0;

        if (w_all_sw) begin
            w_state_d = ALIVE;
            w_lives_d = c_START_LIVES;
            w_x_d     = c_START_X;
            w_y_d     = c_MAX_Y;
            w_cnt_d   = '0;
        end else begin
            unique case (r_state)
                ALIVE: begin
                    if (reset_frog) begin
                        w_x_d = c_START_X;
                        w_y_d = c_MAX_Y;
                    end else if (collision && (r_y != 4'd0)) begin
                        if (r_lives > 2'd1) begin
                            // Frog stays frozen on the collision cell.
                            w_lives_d = r_lives - 2'd1;
                            w_state_d = DYING;
                            w_cnt_d   = '0;
                        end else begin
                            w_lives_d       = 2'd0;
                            w_state_d       = GAME_OVER;
                            w_reset_level_d = 1'b1;
                        end
                    end else begin
                        w_x_d = w_mv_x;
                        w_y_d = w_mv_y;
                    end
                end
                DYING: begin
                    if (r_cnt == c_LAST_CNT) begin
                        w_cnt_d   = '0;
                        w_state_d = ALIVE;
                        w_x_d     = c_START_X;
                        w_y_d     = c_MAX_Y;
                    end else begin
                        w_cnt_d = r_cnt + c_CNT_W'(1);
                    end
                end
                GAME_OVER: begin
                    if (w_any_edge) begin
                        w_state_d = ALIVE;
                        w_lives_d = c_START_LIVES;
                        w_x_d     = c_START_X;
                        w_y_d     = c_MAX_Y;
                    end
                end
                default: begin
                    w_state_d = ALIVE;
                end
            endcase
        end

        // Registered flag tracks the next frog row so it changes with frog_y.
        w_top_d = (w_state_d == ALIVE) && (w_y_d == 4'd0);
    end

    // History registers reset high so a switch held through reset is not
    // seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ALIVE;
            r_x           <= c_START_X;
            r_y           <= c_MAX_Y;
            r_lives       <= c_START_LIVES;
            r_cnt         <= '0;
            r_sw_q        <= 4'b1111;
            r_top         <= 1'b0;
            r_reset_level <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_x           <= w_x_d;
            r_y           <= w_y_d;
            r_lives       <= w_lives_d;
            r_cnt         <= w_cnt_d;
            r_sw_q        <= w_sw;
            r_top         <= w_top_d;
            r_reset_level <= w_reset_level_d;
        end
    end

    assign frog_x      = r_x;
    assign frog_y      = r_y;
    assign frog_at_top = r_top;
    assign lives       = r_lives;
    assign reset_level = r_reset_level;

endmodule
`default_nettype wire
